legv8_multicycle_ctrl: RTL
==========================

Name: legv8_multicycle_ctrl

Overview:
Multi-cycle sequencer for the LEGv8 datapath: one shared ALU, register file and memory ports, with a variable-latency instruction fetch and data access.
- Fetches one instruction per pass into an internal instruction register (IR) and decodes it.
- Steps the datapath through EXEC/MEM/WB, driving the same CONTROL_* select bits the single-cycle datapath uses, plus PC/IR write strobes.
- Waits on READY handshakes from instruction and data memory.

Parameters:
TIMEOUT_CYCLES, 0, max cycles to wait on IMEM_READY/DMEM_READY before entering HALT with BUS_ERROR=1; 0 disables the watchdog
RETIRE_W, 32, width of RETIRE_COUNT (used only with CTRL_RETIRE_CNT_EN)

Ports:
CLOCK  in  1  single clock; all state updates on posedge
RESET  in  1  asynchronous, active-high reset
INSTRUCTION  in  32  instruction memory read data
IMEM_READY  in  1  instruction read data valid this cycle
DMEM_READY  in  1  data access completes this cycle
ALU_ZERO  in  1  ALU zero flag
IMEM_REQ  out  1  instruction read request
IR_WRITE  out  1  IR load strobe
PC_WRITE  out  1  PC update strobe
PC_SRC  out  1  0 = PC+4, 1 = PC + (sign-extended imm << 2)
CONTROL_REG2LOC, CONTROL_ALUSRC, CONTROL_MEM2REG  out  1 each  datapath selects
CONTROL_ALU_OP  out  2  00 add, 01 pass-B/CB, 10 R-type funct
CONTROL_REGWRITE, CONTROL_MEMREAD, CONTROL_MEMWRITE  out  1 each  strobes
IR  out  32  latched instruction
STATE  out  3  debug state
ILLEGAL  out  1  sticky undecodable opcode
BUS_ERROR  out  1  sticky watchdog expiry

Behaviour:
- Reset: asynchronous; STATE=FETCH(0), IR=0, all outputs 0. Reset mid-instruction aborts it with no PC, register or memory write.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Decode classes (IR[31:21]):
  - LDUR 11111000010; STUR 11111000000
  - ADD 10001011000; SUB 11001011000; AND 10001010000; ORR 10101010000
  - CBZ: IR[31:24]=10110100; B: IR[31:26]=000101
  - anything else is illegal.
- FETCH: IMEM_REQ=1. If IMEM_READY is high the same cycle, IR_WRITE=1, IR<=INSTRUCTION, next DECODE; otherwise stay. A ready that arrives on the state's first cycle is accepted (zero-wait). READY while not requesting is ignored.
- DECODE, one cycle:
  - legal opcode -> EXEC
  - illegal -> HALT, ILLEGAL=1.
- Select bits are registered at DECODE exit and held constant through EXEC/MEM/WB. Values:
  - LDUR: 0/1/1/00 (REG2LOC/ALUSRC/MEM2REG/ALU_OP)
  - STUR: 1/1/0/00
  - R-type: 0/0/0/10
  - CBZ: 1/0/0/01
  - B: 0/0/0/01
- EXEC:
  - B: PC_WRITE=1, PC_SRC=1 -> FETCH.
  - CBZ: PC_WRITE=1, PC_SRC=ALU_ZERO -> FETCH.
  - LDUR/STUR -> MEM.
  - R-type -> WB.
- MEM: MEMREAD (LDUR) or MEMWRITE (STUR) held high until DMEM_READY.
  - On ready, STUR: PC_WRITE=1, PC_SRC=0 -> FETCH.
  - On ready, LDUR -> WB.
- WB: REGWRITE=1, PC_WRITE=1, PC_SRC=0 for exactly one cycle -> FETCH.
- Strobes (IR_WRITE, PC_WRITE, REGWRITE, MEMREAD, MEMWRITE) are Moore/Mealy outputs of the current state only; never high in HALT.
- Latency with zero-wait memory: B/CBZ 3 cycles, R-type 4, STUR 4, LDUR 5. Each wait cycle adds one.
- Watchdog (TIMEOUT_CYCLES>0):
  - counts consecutive wait cycles in FETCH or MEM; cleared on READY or state change.
  - at count==TIMEOUT_CYCLES -> HALT, BUS_ERROR=1, request deasserted.
- HALT: absorbing until RESET.

Optional Feature:
CTRL_RETIRE_CNT_EN:
- Defined: adds output RETIRE_COUNT [RETIRE_W-1:0], reset 0, +1 on every PC_WRITE (one per retired instruction), wraps to 0 at all-ones, frozen in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package legv8_ctrl_pkg:
  - state encoding constants
  - 11-bit opcode constants and CBZ/B prefixes
  - ALU_OP encodings 00/01/10
  - instruction-class enum (LDUR, STUR, RTYPE, CBZ, B, ILLEGAL)
- Sub-module legv8_decoder: combinational IR -> class and select bits; the FSM registers its outputs at DECODE.

Test Plan:
- ADD x5,x3,x2 (0x8B020065), zero-wait -> IR_WRITE@c0, REGWRITE+PC_WRITE (PC_SRC=0) @c3, ALU_OP=10, 4 cycles total.
- LDUR x2,[x10] (0xF8400142), DMEM_READY delayed 3 cycles -> MEMREAD high 4 cycles, then WB REGWRITE with MEM2REG=1; 8 cycles total.
- CBZ x1 (0xB4000041) -> ALU_ZERO=0: PC_WRITE with PC_SRC=0; ALU_ZERO=1: PC_SRC=1; REG2LOC=1 in both; 3 cycles each.
- Opcode 0xFFFFFFFF -> DECODE->HALT, ILLEGAL=1, no strobes afterwards until RESET.
- TIMEOUT_CYCLES=4, IMEM_READY held low -> BUS_ERROR=1, STATE=5 after 4 wait cycles; IMEM_REQ drops.
- RESET asserted mid-MEM of STUR (0xF80010E4) -> MEMWRITE drops asynchronously; after release STATE=FETCH, PC_WRITE never pulsed for the aborted instruction; RETIRE_COUNT=0 when CTRL_RETIRE_CNT_EN is defined.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: shared encodings for the LEGv8 multi-cycle controller.
// The optional RETIRE_COUNT output is enabled with CTRL_RETIRE_CNT_EN.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        C_LDUR,
        C_STUR,
        C_RTYPE,
        C_CBZ,
        C_B,
        C_ILLEGAL
    } class_e;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [7:0]  PFX_CBZ = 8'b10110100;
    localparam logic [5:0]  PFX_B   = 6'b000101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

endpackage

// File: rtl/legv8_decoder.sv
// legv8_decoder: combinational IR[31:21] -> instruction class and datapath selects.
module legv8_decoder
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] opcode_i,
    output logic [2:0]  class_o,
    output logic        reg2loc_o,
    output logic        alusrc_o,
    output logic        mem2reg_o,
    output logic [1:0]  alu_op_o
);

    class_e cls;

    always_comb begin
        cls = (opcode_i == OP_LDUR) ? C_LDUR :
              (opcode_i == OP_STUR) ? C_STUR :
              (opcode_i inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) ? C_RTYPE :
              (opcode_i[10:3] == PFX_CBZ) ? C_CBZ :
              (opcode_i[10:5] == PFX_B) ? C_B : C_ILLEGAL;
        class_o   = cls;
        reg2loc_o = (cls == C_STUR) || (cls == C_CBZ);
        alusrc_o  = (cls == C_LDUR) || (cls == C_STUR);
        mem2reg_o = (cls == C_LDUR);
        alu_op_o  = (cls == C_RTYPE) ? ALU_RTYPE :
                    (cls == C_CBZ || cls == C_B) ? ALU_PASSB : ALU_ADD;
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with READY handshakes and watchdog.
// Define CTRL_RETIRE_CNT_EN to add the RETIRE_COUNT output.
module legv8_multicycle_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
`ifdef CTRL_RETIRE_CNT_EN
    , parameter int unsigned RETIRE_W = 32
`endif
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] instruction_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    input  logic        alu_zero_i,
    output logic        imem_req_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        control_reg2loc_o,
    output logic        control_alusrc_o,
    output logic        control_mem2reg_o,
    output logic [1:0]  control_alu_op_o,
    output logic        control_regwrite_o,
    output logic        control_memread_o,
    output logic        control_memwrite_o,
    output logic [31:0] ir_o,
    output logic [2:0]  state_o,
    output logic        illegal_o,
    output logic        bus_error_o
`ifdef CTRL_RETIRE_CNT_EN
    , output logic [RETIRE_W-1:0] retire_count_o
`endif
);

    state_e      state_q, state_d;
    class_e      class_q;
    logic [31:0] ir_q;
    logic        reg2loc_q, alusrc_q, mem2reg_q;
    logic [1:0]  alu_op_q;
    logic        illegal_q, bus_err_q;
    logic [31:0] wd_q, wd_d;
    logic [2:0]  dec_class;
    logic        dec_reg2loc, dec_alusrc, dec_mem2reg;
    logic [1:0]  dec_alu_op;
    logic        waiting, timeout;

    legv8_decoder u_dec (
        .opcode_i  (ir_q[31:21]),
        .class_o   (dec_class),
        .reg2loc_o (dec_reg2loc),
        .alusrc_o  (dec_alusrc),
        .mem2reg_o (dec_mem2reg),
        .alu_op_o  (dec_alu_op)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    // A wait cycle is any FETCH/MEM cycle whose handshake has not completed.
    always_comb begin
        waiting = (state_q == S_FETCH && !imem_ready_i) || (state_q == S_MEM && !dmem_ready_i);
        timeout = (TIMEOUT_CYCLES != 0) && waiting && (wd_q == 32'(TIMEOUT_CYCLES - 1));
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  state_d = imem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: state_d = (class_e'(dec_class) == C_ILLEGAL) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (class_q == C_B || class_q == C_CBZ) ? S_FETCH :
                                (class_q == C_RTYPE) ? S_WB : S_MEM;
            S_MEM:    state_d = !dmem_ready_i ? S_MEM : (class_q == C_STUR) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
        if (timeout) state_d = S_HALT;
        wd_d = (waiting && state_d == state_q) ? wd_q + 32'd1 : 32'd0;
    end

    always_comb begin
        imem_req_o         = (state_q == S_FETCH);
        ir_write_o         = (state_q == S_FETCH) && imem_ready_i;
        control_regwrite_o = (state_q == S_WB);
        control_memread_o  = (state_q == S_MEM) && (class_q == C_LDUR);
        control_memwrite_o = (state_q == S_MEM) && (class_q == C_STUR);
        pc_write_o         = (state_q == S_WB) ||
                             (state_q == S_EXEC && (class_q == C_B || class_q == C_CBZ)) ||
                             (state_q == S_MEM && class_q == C_STUR && dmem_ready_i);
        pc_src_o           = (state_q == S_EXEC) &&
                             ((class_q == C_B) || (class_q == C_CBZ && alu_zero_i));
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ir_q      <= 32'd0;
            class_q   <= C_LDUR;
            reg2loc_q <= 1'b0;
            alusrc_q  <= 1'b0;
            mem2reg_q <= 1'b0;
            alu_op_q  <= 2'b00;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            wd_q      <= 32'd0;
        end else begin
            wd_q <= wd_d;
            if (ir_write_o) ir_q <= instruction_i;
            if (state_q == S_DECODE && class_e'(dec_class) != C_ILLEGAL) begin
                class_q   <= class_e'(dec_class);
                reg2loc_q <= dec_reg2loc;
                alusrc_q  <= dec_alusrc;
                mem2reg_q <= dec_mem2reg;
                alu_op_q  <= dec_alu_op;
            end
            if (state_q == S_DECODE && class_e'(dec_class) == C_ILLEGAL) illegal_q <= 1'b1;
            if (timeout) bus_err_q <= 1'b1;
        end
    end

    assign control_reg2loc_o = reg2loc_q;
    assign control_alusrc_o  = alusrc_q;
    assign control_mem2reg_o = mem2reg_q;
    assign control_alu_op_o  = alu_op_q;
    assign ir_o              = ir_q;
    assign state_o           = state_q;
    assign illegal_o         = illegal_q;
    assign bus_error_o       = bus_err_q;

`ifdef CTRL_RETIRE_CNT_EN
    // PC_WRITE is never high in HALT, so the count freezes there on its own.
    logic [RETIRE_W-1:0] retire_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)         retire_q <= '0;
        else if (pc_write_o) retire_q <= retire_q + 1'b1;
    end

    assign retire_count_o = retire_q;
`endif

endmodule
